// File: rtl/lc3_pipe_ctrl.sv
// lc3_pipe_ctrl: pipeline sequencer for the LC-3 five-stage datapath.
//
// Ports
//   clock, reset          rising-edge clock, asynchronous active-low reset
//   complete_instr        instruction memory returned valid data this cycle
//   complete_data         data memory access finished this cycle
//   ir                    instruction at the decode-stage output
//   ir_exec               instruction currently in execute
//   nzp                   condition codes {n,z,p}
//   enable_fetch/decode/execute/writeback/updatePC   stage enables
//   mem_state             0 read, 1 indirect-address read, 2 write, 3 idle
//   br_taken              PC loads the execute target instead of PC+1
//   bypass_alu_1/2        forward the ALU result to SR1 / SR2
//
// Enables and mem_state are registered from the next state, so they always match
// the state register. br_taken and the bypass selects are decoded combinationally.
module lc3_pipe_ctrl #(
  parameter int unsigned INSTRUCTION_WIDTH = 16,
  parameter int unsigned NZP_WIDTH         = 3
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         complete_instr,
  input  logic                         complete_data,
  input  logic [INSTRUCTION_WIDTH-1:0] ir,
  input  logic [INSTRUCTION_WIDTH-1:0] ir_exec,
  input  logic [NZP_WIDTH-1:0]         nzp,
  output logic                         enable_fetch,
  output logic                         enable_decode,
  output logic                         enable_execute,
  output logic                         enable_writeback,
  output logic                         enable_updatePC,
  output logic [1:0]                   mem_state,
  output logic                         br_taken,
  output logic                         bypass_alu_1,
  output logic                         bypass_alu_2
);

  localparam logic [3:0] OpBr  = 4'b0000;
  localparam logic [3:0] OpAdd = 4'b0001;
  localparam logic [3:0] OpLd  = 4'b0010;
  localparam logic [3:0] OpSt  = 4'b0011;
  localparam logic [3:0] OpAnd = 4'b0101;
  localparam logic [3:0] OpLdr = 4'b0110;
  localparam logic [3:0] OpStr = 4'b0111;
  localparam logic [3:0] OpNot = 4'b1001;
  localparam logic [3:0] OpLdi = 4'b1010;
  localparam logic [3:0] OpSti = 4'b1011;
  localparam logic [3:0] OpJmp = 4'b1100;

  localparam logic [1:0] MemRead  = 2'd0;
  localparam logic [1:0] MemInd   = 2'd1;
  localparam logic [1:0] MemWrite = 2'd2;
  localparam logic [1:0] MemIdle  = 2'd3;

  typedef enum logic [3:0] {
    StRst,
    StF1,
    StF2,
    StF3,
    StF4,
    StRun,
    StStall,
    StMemA,
    StMemB,
    StMemWb,
    StCw,
    StCr
  } state_e;

  function automatic logic is_alu_op(input logic [3:0] op);
    return (op == OpAdd) || (op == OpAnd) || (op == OpNot);
  endfunction

  function automatic logic is_mem_op(input logic [3:0] op);
    return (op == OpLd) || (op == OpLdr) || (op == OpLdi) ||
           (op == OpSt) || (op == OpStr) || (op == OpSti);
  endfunction

  function automatic logic is_ctl_op(input logic [3:0] op);
    return (op == OpBr) || (op == OpJmp);
  endfunction

  state_e               state_q, state_d;
  logic [3:0]           mop_q, mop_d;
  logic                 ctl_jmp_q, ctl_jmp_d;
  logic [NZP_WIDTH-1:0] mask_q, mask_d;
  logic [4:0]           en_q, en_d;    // {fetch, decode, execute, writeback, updatePC}
  logic [1:0]           mem_q, mem_d;

  logic [3:0] dec_op, exec_op;
  assign dec_op  = ir[15:12];
  assign exec_op = ir_exec[15:12];

  // Next-state and latched-field logic.
  always_comb begin
    state_d   = state_q;
    mop_d     = mop_q;
    ctl_jmp_d = ctl_jmp_q;
    mask_d    = mask_q;
    unique case (state_q)
      StRst: state_d = StF1;
      StF1:  state_d = StF2;
      StF2:  state_d = StF3;
      StF3:  state_d = StF4;
      StF4:  state_d = StRun;
      StRun: begin
        // A memory op in execute wins over a control op in decode; decode is frozen
        // during the access, so the control op is seen again afterwards.
        if (is_mem_op(exec_op)) begin
          mop_d   = exec_op;
          state_d = StMemA;
        end else if (is_ctl_op(dec_op)) begin
          state_d = StCw;
        end else if (!complete_instr) begin
          state_d = StStall;
        end
      end
      StStall: begin
        if (complete_instr) state_d = StRun;
      end
      StMemA: begin
        if (complete_data) begin
          if ((mop_q == OpLdi) || (mop_q == OpSti)) begin
            state_d = StMemB;
          end else if ((mop_q == OpLd) || (mop_q == OpLdr)) begin
            state_d = StMemWb;
          end else begin
            state_d = StRun;
          end
        end
      end
      StMemB: begin
        if (complete_data) state_d = (mop_q == OpLdi) ? StMemWb : StRun;
      end
      StMemWb: state_d = StRun;
      StCw: begin
        ctl_jmp_d = (exec_op == OpJmp);
        mask_d    = ir_exec[9 +: NZP_WIDTH];
        state_d   = StCr;
      end
      StCr:    state_d = StF1;
      default: state_d = StRst;
    endcase
  end

  // Moore output decode of the upcoming state, registered alongside it.
  always_comb begin
    en_d  = 5'b00000;
    mem_d = MemIdle;
    unique case (state_d)
      StF1:         en_d = 5'b10001;
      StF2:         en_d = 5'b11001;
      StF3:         en_d = 5'b11101;
      StF4, StRun:  en_d = 5'b11111;
      StMemWb:      en_d = 5'b00010;
      StCw:         en_d = 5'b00110;
      StCr:         en_d = 5'b00001;
      StMemA: begin
        if ((mop_d == OpLdi) || (mop_d == OpSti)) begin
          mem_d = MemInd;
        end else if ((mop_d == OpSt) || (mop_d == OpStr)) begin
          mem_d = MemWrite;
        end else begin
          mem_d = MemRead;
        end
      end
      StMemB:  mem_d = (mop_d == OpSti) ? MemWrite : MemRead;
      default: en_d = 5'b00000;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= StRst;
      mop_q     <= 4'b0000;
      ctl_jmp_q <= 1'b0;
      mask_q    <= '0;
      en_q      <= 5'b00000;
      mem_q     <= MemIdle;
    end else begin
      state_q   <= state_d;
      mop_q     <= mop_d;
      ctl_jmp_q <= ctl_jmp_d;
      mask_q    <= mask_d;
      en_q      <= en_d;
      mem_q     <= mem_d;
    end
  end

  assign enable_fetch     = en_q[4];
  assign enable_decode    = en_q[3];
  assign enable_execute   = en_q[2];
  assign enable_writeback = en_q[1];
  assign enable_updatePC  = en_q[0];
  assign mem_state        = mem_q;

  assign br_taken = (state_q == StCr) & (ctl_jmp_q | (|(mask_q & nzp)));

  logic in_run;
  assign in_run = (state_q == StRun);

  assign bypass_alu_1 = in_run & is_alu_op(exec_op) & is_alu_op(dec_op) &
                        (ir_exec[11:9] == ir[8:6]);
  assign bypass_alu_2 = in_run & is_alu_op(exec_op) &
                        ((dec_op == OpAdd) || (dec_op == OpAnd)) & ~ir[5] &
                        (ir_exec[11:9] == ir[2:0]);

  // Instruction fields this block never looks at.
  logic unused_fields;
  assign unused_fields = ^{ir[11:9], ir[4:3], ir_exec[8:0]};

endmodule

// File: tb/tb_lc3_pipe_ctrl.sv
module tb_lc3_pipe_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic        complete_instr;
  logic        complete_data;
  logic [15:0] ir;
  logic [15:0] ir_exec;
  logic [2:0]  nzp;
  logic        enable_fetch, enable_decode, enable_execute, enable_writeback, enable_updatePC;
  logic [1:0]  mem_state;
  logic        br_taken, bypass_alu_1, bypass_alu_2;

  lc3_pipe_ctrl #(
    .INSTRUCTION_WIDTH(16),
    .NZP_WIDTH        (3)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .complete_instr  (complete_instr),
    .complete_data   (complete_data),
    .ir              (ir),
    .ir_exec         (ir_exec),
    .nzp             (nzp),
    .enable_fetch    (enable_fetch),
    .enable_decode   (enable_decode),
    .enable_execute  (enable_execute),
    .enable_writeback(enable_writeback),
    .enable_updatePC (enable_updatePC),
    .mem_state       (mem_state),
    .br_taken        (br_taken),
    .bypass_alu_1    (bypass_alu_1),
    .bypass_alu_2    (bypass_alu_2)
  );

  always #5 clock = ~clock;

  int n_vec = 0;
  int n_err = 0;

  localparam logic [15:0] Nop = 16'h1000;  // ADD R0,R0,R0: ALU, not memory, not control

  // ---------------- behavioural model ----------------
  // Pipeline activity as a phase name plus a queue of pending memory accesses.
  typedef enum int {MReset, MFill, MRun, MStall, MMem, MWb, MCtlWait, MCtlRes} mphase_e;
  mphase_e m_phase = MReset;
  int      m_fill  = 0;
  int      plan[$];       // outstanding access kinds, front = current
  bit      plan_wb = 0;   // a lone writeback follows the last access
  bit      m_jmp   = 0;
  logic [2:0] m_mask = 3'b000;

  function automatic bit op_alu(input logic [3:0] op);
    return op == 4'h1 || op == 4'h5 || op == 4'h9;
  endfunction
  function automatic bit op_mem(input logic [3:0] op);
    return op == 4'h2 || op == 4'h6 || op == 4'ha || op == 4'h3 || op == 4'h7 || op == 4'hb;
  endfunction
  function automatic bit op_ctl(input logic [3:0] op);
    return op == 4'h0 || op == 4'hc;
  endfunction

  task automatic cmp(input string name, input int act, input int want);
    n_vec++;
    if (act != want) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, want);
    end
  endtask

  function automatic int act_en();
    return {27'd0, enable_fetch, enable_decode, enable_execute, enable_writeback,
            enable_updatePC};
  endfunction

  task automatic check_model();
    int e_en, e_mem, e_br, e_b1, e_b2;
    e_en = 0; e_mem = 3; e_br = 0; e_b1 = 0; e_b2 = 0;
    if (reset) begin
      case (m_phase)
        MFill:    e_en = 5'b10001 | (m_fill >= 2 ? 5'b01000 : 0) | (m_fill >= 3 ? 5'b00100 : 0)
                         | (m_fill >= 4 ? 5'b00010 : 0);
        MRun: begin
          e_en = 5'b11111;
          e_b1 = int'(op_alu(ir_exec[15:12]) && op_alu(ir[15:12]) && ir_exec[11:9] == ir[8:6]);
          e_b2 = int'(op_alu(ir_exec[15:12]) && (ir[15:12] == 4'h1 || ir[15:12] == 4'h5) &&
                      !ir[5] && ir_exec[11:9] == ir[2:0]);
        end
        MMem:     e_mem = plan[0];
        MWb:      e_en = 5'b00010;
        MCtlWait: e_en = 5'b00110;
        MCtlRes: begin
          e_en = 5'b00001;
          e_br = int'(m_jmp || ((m_mask & nzp) != 3'b000));
        end
        default: ;
      endcase
    end
    cmp("enables", act_en(), e_en);
    cmp("mem_state", int'(mem_state), e_mem);
    cmp("br_taken", int'(br_taken), e_br);
    cmp("bypass_alu_1", int'(bypass_alu_1), e_b1);
    cmp("bypass_alu_2", int'(bypass_alu_2), e_b2);
  endtask

  task automatic advance_model();
    logic [3:0] xop;
    xop = ir_exec[15:12];
    if (!reset) begin
      m_phase = MReset;
      plan.delete();
      return;
    end
    case (m_phase)
      MReset: begin m_phase = MFill; m_fill = 1; end
      MFill:  if (m_fill < 4) m_fill++; else m_phase = MRun;
      MRun: begin
        if (op_mem(xop)) begin
          plan.delete();
          case (xop)
            4'h2, 4'h6: begin plan.push_back(0); plan_wb = 1; end
            4'h3, 4'h7: begin plan.push_back(2); plan_wb = 0; end
            4'ha:       begin plan.push_back(1); plan.push_back(0); plan_wb = 1; end
            default:    begin plan.push_back(1); plan.push_back(2); plan_wb = 0; end
          endcase
          m_phase = MMem;
        end else if (op_ctl(ir[15:12])) m_phase = MCtlWait;
        else if (!complete_instr) m_phase = MStall;
      end
      MStall: if (complete_instr) m_phase = MRun;
      MMem: if (complete_data) begin
        void'(plan.pop_front());
        if (plan.size() == 0) m_phase = plan_wb ? MWb : MRun;
      end
      MWb: m_phase = MRun;
      MCtlWait: begin
        m_jmp   = (xop == 4'hc);
        m_mask  = ir_exec[11:9];
        m_phase = MCtlRes;
      end
      MCtlRes: begin m_phase = MFill; m_fill = 1; end
      default: m_phase = MReset;
    endcase
  endtask

  // One cycle: compare at the falling edge, advance model at the rising edge,
  // return just after the edge so callers can drive the next cycle's inputs.
  task automatic step();
    @(negedge clock);
    check_model();
    @(posedge clock);
    advance_model();
    #1;
  endtask

  task automatic ctl_case(input logic [15:0] ctl, input logic [2:0] cc, input int want_br);
    ir = ctl; ir_exec = Nop; nzp = cc;
    step();
    cmp("cw_enables", act_en(), 5'b00110);
    ir_exec = ctl; ir = Nop;
    step();
    cmp("cr_enables", act_en(), 5'b00001);
    cmp("cr_br_taken", int'(br_taken), want_br);
    ir_exec = Nop;
    step();
    cmp("refill_f1", act_en(), 5'b10001);
    repeat (4) step();
    cmp("refill_run", act_en(), 5'b11111);
  endtask

  function automatic logic [15:0] rand_exec();
    int r;
    logic [3:0] op;
    r = $urandom_range(0, 99);
    if (r < 60) begin
      case ($urandom_range(0, 2)) 0: op = 4'h1; 1: op = 4'h5; default: op = 4'h9; endcase
    end else if (r < 85) begin
      case ($urandom_range(0, 5))
        0: op = 4'h2; 1: op = 4'h6; 2: op = 4'ha; 3: op = 4'h3; 4: op = 4'h7; default: op = 4'hb;
      endcase
    end else op = 4'($urandom_range(0, 15));
    return {op, 12'($urandom)};
  endfunction

  function automatic logic [15:0] rand_dec();
    int r;
    logic [3:0] op;
    r = $urandom_range(0, 99);
    if (r < 80) begin
      case ($urandom_range(0, 2)) 0: op = 4'h1; 1: op = 4'h5; default: op = 4'h9; endcase
    end else if (r < 90) op = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'hc;
    else op = 4'($urandom_range(0, 15));
    return {op, 12'($urandom)};
  endfunction

  initial begin
    reset = 1'b0; complete_instr = 1'b1; complete_data = 1'b0;
    ir = Nop; ir_exec = Nop; nzp = 3'b000;
    #1;

    // Reset fill sequence.
    repeat (3) step();
    cmp("reset_enables", act_en(), 0);
    cmp("reset_mem_state", int'(mem_state), 3);
    reset = 1'b1;
    step(); cmp("fill_f1", act_en(), 5'b10001); cmp("fill_mem", int'(mem_state), 3);
    step(); cmp("fill_f2", act_en(), 5'b11001);
    step(); cmp("fill_f3", act_en(), 5'b11101);
    step(); cmp("fill_f4", act_en(), 5'b11111);
    step(); cmp("fill_run", act_en(), 5'b11111);

    // LDR with data returning on the third access cycle.
    ir_exec = 16'h6285;
    step(); cmp("ldr_a1_mem", int'(mem_state), 0); cmp("ldr_a1_en", act_en(), 0);
    ir_exec = Nop;
    step(); cmp("ldr_a2_mem", int'(mem_state), 0);
    step(); cmp("ldr_a3_mem", int'(mem_state), 0);
    complete_data = 1'b1;
    step(); cmp("ldr_wb_en", act_en(), 5'b00010); cmp("ldr_wb_mem", int'(mem_state), 3);
    complete_data = 1'b0;
    step(); cmp("ldr_run", act_en(), 5'b11111);

    // STI with data strobe held high.
    ir_exec = 16'hB401; complete_data = 1'b1;
    step(); cmp("sti_a_mem", int'(mem_state), 1);
    ir_exec = Nop;
    step(); cmp("sti_b_mem", int'(mem_state), 2); cmp("sti_b_en", act_en(), 0);
    step(); cmp("sti_run", act_en(), 5'b11111); cmp("sti_run_mem", int'(mem_state), 3);
    complete_data = 1'b0;

    // Branch / jump resolution.
    ctl_case(16'h0A05, 3'b001, 1);
    ctl_case(16'h0A05, 3'b010, 0);
    ctl_case(16'hC1C0, 3'b000, 1);

    // ALU bypass and instruction-fetch stall.
    ir_exec = 16'h1282; ir = 16'h1642;
    #1; cmp("byp1_hit", int'(bypass_alu_1), 1); cmp("byp2_miss", int'(bypass_alu_2), 0);
    ir = 16'h1681;
    #1; cmp("byp1_miss", int'(bypass_alu_1), 0); cmp("byp2_hit", int'(bypass_alu_2), 1);
    ir = 16'h1642; complete_instr = 1'b0;
    step(); cmp("stall1_en", act_en(), 0); cmp("stall1_byp", int'(bypass_alu_1), 0);
    step(); cmp("stall2_en", act_en(), 0);
    step(); cmp("stall3_en", act_en(), 0);
    complete_instr = 1'b1;
    step(); cmp("stall_resume", act_en(), 5'b11111); cmp("resume_byp1", int'(bypass_alu_1), 1);

    // Asynchronous reset in the middle of a memory access.
    ir = Nop; ir_exec = 16'h6285;
    step(); cmp("mid_mem_a", int'(mem_state), 0);
    ir_exec = Nop;
    #2 reset = 1'b0;
    #1; cmp("async_rst_en", act_en(), 0); cmp("async_rst_mem", int'(mem_state), 3);
    step(); step();
    reset = 1'b1;
    step(); cmp("refill2_f1", act_en(), 5'b10001);
    repeat (4) step();
    cmp("refill2_run", act_en(), 5'b11111);

    // Randomized traffic, including occasional mid-cycle resets.
    for (int i = 0; i < 3000; i++) begin
      ir_exec        = rand_exec();
      ir             = rand_dec();
      nzp            = 3'($urandom_range(0, 7));
      complete_instr = ($urandom_range(0, 99) < 85);
      complete_data  = ($urandom_range(0, 99) < 40);
      if (!reset) reset = 1'b1;
      else if ($urandom_range(0, 199) == 0) reset = 1'b0;
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
